// File: rtl/psg_arb_pkg.sv
// Shared types and constants for the PSG bus arbiter: FSM states, default widths,
// and AY-3-8910 register addresses.
package psg_arb_pkg;

  localparam int REG_W_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_WR,
    PLY_ADDR,
    PLY_DATA,
    RESTORE
  } arb_state_t;

  localparam logic [3:0] PSG_TONE_A_FINE  = 4'h0;
  localparam logic [3:0] PSG_NOISE_PERIOD = 4'h6;
  localparam logic [3:0] PSG_MIXER        = 4'h7;
  localparam logic [3:0] PSG_VOL_A        = 4'h8;
  localparam logic [3:0] PSG_ENV_FINE     = 4'hB;
  localparam logic [3:0] PSG_ENV_COARSE   = 4'hC;
  localparam logic [3:0] PSG_ENV_SHAPE    = 4'hD;
  localparam logic [3:0] PSG_IO_A         = 4'hE;
  localparam logic [3:0] PSG_IO_B         = 4'hF;

endpackage

// File: rtl/psg_arb_grant.sv
// CPU/player tie resolution, combinational grant; exactly one side is granted at any time.
// PSG_ARB_ROUND_ROBIN_EN: last-served side loses a tie (flag resets to player); else CPU always wins.
module psg_arb_grant (
`ifdef PSG_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
  input  logic cpu_accept,
  input  logic ply_accept,
`endif
  input  logic cpu_valid,
  input  logic ply_valid,
  output logic grant_cpu,
  output logic grant_ply
);

  logic prefer_cpu;

`ifdef PSG_ARB_ROUND_ROBIN_EN
  logic last_cpu;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu <= 1'b0;
    end else if (cpu_accept) begin
      last_cpu <= 1'b1;
    end else if (ply_accept) begin
      last_cpu <= 1'b0;
    end
  end

  assign prefer_cpu = !last_cpu;
`else
  assign prefer_cpu = 1'b1;
`endif

  // A lone requester always wins; otherwise (tie or nobody) the preferred side holds the grant.
  assign grant_cpu = cpu_valid ? (prefer_cpu || !ply_valid) : (prefer_cpu && !ply_valid);
  assign grant_ply = !grant_cpu;

endmodule

// File: rtl/psg_bus_arbiter.sv
// Shares the AY-3-8910 register bus between CPU and music player; player pairs become addr+data strobes,
// then the CPU's register selection is restored. Readies only in IDLE. Tie policy: PSG_ARB_ROUND_ROBIN_EN.
module psg_bus_arbiter
  import psg_arb_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_a0,
  input  logic [DATA_W-1:0] cpu_wrdata,
  output logic              cpu_ready,
  input  logic              ply_valid,
  input  logic [REG_W-1:0]  ply_reg,
  input  logic [DATA_W-1:0] ply_data,
  output logic              ply_ready,
  output logic              psg_wren,
  output logic              psg_a0,
  output logic [DATA_W-1:0] psg_wrdata,
  output logic [REG_W-1:0]  shadow_addr
);

  arb_state_t        state;
  logic              restore_pend;
  logic [REG_W-1:0]  ply_reg_q;
  logic [DATA_W-1:0] ply_data_q;
  logic              grant_cpu;
  logic              grant_ply;
  logic              can_accept;
  logic              cpu_accept;
  logic              ply_accept;

  psg_arb_grant u_grant (
`ifdef PSG_ARB_ROUND_ROBIN_EN
    .clk        (clk),
    .reset      (reset),
    .cpu_accept (cpu_accept),
    .ply_accept (ply_accept),
`endif
    .cpu_valid  (cpu_valid),
    .ply_valid  (ply_valid),
    .grant_cpu  (grant_cpu),
    .grant_ply  (grant_ply)
  );

  assign can_accept = (state == IDLE) && !restore_pend;
  assign cpu_ready  = can_accept && grant_cpu;
  assign ply_ready  = can_accept && grant_ply;
  assign cpu_accept = cpu_valid && cpu_ready;
  assign ply_accept = ply_valid && ply_ready;

  // Outputs are registered together with the state, so psg_wren is high exactly in the strobe states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      restore_pend <= 1'b1;
      psg_wren     <= 1'b0;
      psg_a0       <= 1'b0;
      psg_wrdata   <= '0;
      shadow_addr  <= '0;
      ply_reg_q    <= '0;
      ply_data_q   <= '0;
    end else begin
      psg_wren   <= 1'b0;
      psg_a0     <= 1'b0;
      psg_wrdata <= '0;
      case (state)
        IDLE: begin
          // The PSG latch survives reset, so it is rewritten before any request is taken.
          if (restore_pend) begin
            state        <= RESTORE;
            restore_pend <= 1'b0;
            psg_wren     <= 1'b1;
            psg_a0       <= 1'b1;
            psg_wrdata   <= DATA_W'(shadow_addr);
          end else if (cpu_accept) begin
            state      <= CPU_WR;
            psg_wren   <= 1'b1;
            psg_a0     <= cpu_a0;
            psg_wrdata <= cpu_wrdata;
            if (cpu_a0) begin
              shadow_addr <= cpu_wrdata[REG_W-1:0];
            end
          end else if (ply_accept) begin
            state      <= PLY_ADDR;
            ply_reg_q  <= ply_reg;
            ply_data_q <= ply_data;
            psg_wren   <= 1'b1;
            psg_a0     <= 1'b1;
            psg_wrdata <= DATA_W'(ply_reg);
          end
        end
        PLY_ADDR: begin
          state      <= PLY_DATA;
          psg_wren   <= 1'b1;
          psg_wrdata <= ply_data_q;
        end
        PLY_DATA: begin
          if (ply_reg_q != shadow_addr) begin
            state      <= RESTORE;
            psg_wren   <= 1'b1;
            psg_a0     <= 1'b1;
            psg_wrdata <= DATA_W'(shadow_addr);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_bus_arbiter.sv
// Randomised and directed bench for psg_bus_arbiter against a strobe-queue reference model.
module tb_psg_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_valid;
  logic       cpu_a0;
  logic [7:0] cpu_wrdata;
  logic       cpu_ready;
  logic       ply_valid;
  logic [3:0] ply_reg;
  logic [7:0] ply_data;
  logic       ply_ready;
  logic       psg_wren;
  logic       psg_a0;
  logic [7:0] psg_wrdata;
  logic [3:0] shadow_addr;

  always #5 clk = ~clk;

  psg_bus_arbiter #(.REG_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_valid   (cpu_valid),
    .cpu_a0      (cpu_a0),
    .cpu_wrdata  (cpu_wrdata),
    .cpu_ready   (cpu_ready),
    .ply_valid   (ply_valid),
    .ply_reg     (ply_reg),
    .ply_data    (ply_data),
    .ply_ready   (ply_ready),
    .psg_wren    (psg_wren),
    .psg_a0      (psg_a0),
    .psg_wrdata  (psg_wrdata),
    .shadow_addr (shadow_addr)
  );

  typedef struct packed {
    logic       wren;
    logic       a0;
    logic [7:0] data;
  } strobe_t;

  // Model: queue of bus cycles still owed by the current transaction; empty queue == idle.
  strobe_t    exp_q[$];
  logic [8:0] obs_log[$];
  logic [3:0] m_shadow = 4'h0;
  bit         m_last_cpu = 1'b0;
  bit         model_on = 1'b0;
  bit         cpu_done;
  bit         ply_done;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_prefer_cpu();
`ifdef PSG_ARB_ROUND_ROBIN_EN
    return !m_last_cpu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    strobe_t e;
    bit idle;
    bit exp_cpu;
    bit exp_ply;
    exp_cpu  = 1'b0;
    exp_ply  = 1'b0;
    cpu_done = 1'b0;
    ply_done = 1'b0;
    @(negedge clk);
    if (model_on) begin
      idle = (exp_q.size() == 0);
      e    = idle ? strobe_t'(0) : exp_q[0];
      check("wren", psg_wren, e.wren);
      check("a0", psg_a0, e.a0);
      check("wrdata", psg_wrdata, e.data);
      check("shadow", shadow_addr, m_shadow);
      if (psg_wren === 1'b1) obs_log.push_back({psg_a0, psg_wrdata});
      if (!reset) begin
        exp_cpu = idle && cpu_valid && (m_prefer_cpu() || !ply_valid);
        exp_ply = idle && ply_valid && (!m_prefer_cpu() || !cpu_valid);
        check("cpu_acc", cpu_valid && cpu_ready, exp_cpu);
        check("ply_acc", ply_valid && ply_ready, exp_ply);
      end
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      exp_q.push_back(strobe_t'(0));
      exp_q.push_back({1'b1, 1'b1, 8'h00});
      m_shadow   = 4'h0;
      m_last_cpu = 1'b0;
      model_on   = 1'b1;
    end else if (model_on) begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end else if (exp_cpu) begin
        exp_q.push_back({1'b1, cpu_a0, cpu_wrdata});
        if (cpu_a0) m_shadow = cpu_wrdata[3:0];
        m_last_cpu = 1'b1;
        cpu_done   = 1'b1;
      end else if (exp_ply) begin
        exp_q.push_back({1'b1, 1'b1, 4'h0, ply_reg});
        exp_q.push_back({1'b1, 1'b0, ply_data});
        if (ply_reg != m_shadow) exp_q.push_back({1'b1, 1'b1, 4'h0, m_shadow});
        m_last_cpu = 1'b0;
        ply_done   = 1'b1;
      end
    end
    #1;
    if (cpu_done) cpu_valid = 1'b0;
    if (ply_done) ply_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_req(input logic a0, input logic [7:0] d);
    cpu_valid  = 1'b1;
    cpu_a0     = a0;
    cpu_wrdata = d;
    for (int i = 0; i < 50 && cpu_valid; i++) step();
    check("cpu_req_timeout", cpu_valid, 1'b0);
    cpu_valid = 1'b0;
  endtask

  task automatic ply_req(input logic [3:0] r, input logic [7:0] d);
    ply_valid = 1'b1;
    ply_reg   = r;
    ply_data  = d;
    for (int i = 0; i < 50 && ply_valid; i++) step();
    check("ply_req_timeout", ply_valid, 1'b0);
    ply_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [8:0] exp[$]);
    check({tag, "_len"}, obs_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), obs_log[i], exp[i]);
  endtask

  initial begin
    bit win[4];
    int got;
    int guard;

    reset      = 1'b1;
    cpu_valid  = 1'b0;
    cpu_a0     = 1'b0;
    cpu_wrdata = 8'h00;
    ply_valid  = 1'b0;
    ply_reg    = 4'h0;
    ply_data   = 8'h00;

    // Reset release with no requests: one address-0 restore strobe.
    step();
    step();
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_ply_ready", ply_ready, 1'b0);
    obs_log.delete();
    reset = 1'b0;
    idle_cycles(4);
    check_log("rst_seq", '{9'h100});
    check("rst_shadow", shadow_addr, 4'h0);

    // CPU select then data write.
    obs_log.delete();
    cpu_req(1'b1, 8'h07);
    cpu_req(1'b0, 8'h38);
    idle_cycles(2);
    check_log("cpu_seq", '{9'h107, 9'h038});
    check("cpu_shadow", shadow_addr, 4'h7);

    // Player write to a different register forces a restore.
    obs_log.delete();
    ply_req(4'h8, 8'h0F);
    idle_cycles(4);
    check_log("ply_restore", '{9'h108, 9'h00F, 9'h107});

    // Player write to the CPU's selected register needs no restore.
    cpu_req(1'b1, 8'h08);
    idle_cycles(1);
    obs_log.delete();
    ply_req(4'h8, 8'h10);
    idle_cycles(4);
    check_log("ply_norestore", '{9'h108, 9'h010});

    // Four back-to-back ties: both requesters kept valid continuously.
    got   = 0;
    guard = 0;
    while (got < 4 && guard < 100) begin
      if (!cpu_valid) begin
        cpu_valid  = 1'b1;
        cpu_a0     = 1'b0;
        cpu_wrdata = 8'($urandom);
      end
      if (!ply_valid) begin
        ply_valid = 1'b1;
        ply_reg   = 4'($urandom);
        ply_data  = 8'($urandom);
      end
      step();
      guard++;
      if (cpu_done) begin
        win[got] = 1'b1;
        got++;
      end else if (ply_done) begin
        win[got] = 1'b0;
        got++;
      end
    end
    check("tie_count", got, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef PSG_ARB_ROUND_ROBIN_EN
      check($sformatf("tie_win%0d", i), win[i], (i % 2 == 0));
`else
      check($sformatf("tie_win%0d", i), win[i], 1'b1);
`endif
    end
    cpu_valid = 1'b0;
    ply_valid = 1'b0;
    idle_cycles(6);

    // Reset while the player data strobe is on the bus; the pair is offered again afterwards.
    ply_valid = 1'b1;
    ply_reg   = 4'h5;
    ply_data  = 8'h55;
    for (int i = 0; i < 50 && ply_valid; i++) step();
    check("rstmid_accept", ply_valid, 1'b0);
    step();
    reset = 1'b1;
    step();
    obs_log.delete();
    step();
    check("rstmid_wren", psg_wren, 1'b0);
    reset = 1'b0;
    ply_req(4'h5, 8'h55);
    idle_cycles(6);
    check_log("rstmid_seq", '{9'h100, 9'h105, 9'h055, 9'h100});
    check("rstmid_shadow", shadow_addr, 4'h0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if (!cpu_valid && $urandom_range(0, 3) == 0) begin
        cpu_valid  = 1'b1;
        cpu_a0     = 1'($urandom_range(0, 1));
        cpu_wrdata = 8'($urandom);
      end
      if (!ply_valid && $urandom_range(0, 2) == 0) begin
        ply_valid = 1'b1;
        ply_reg   = 4'($urandom);
        ply_data  = 8'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset     = 1'b0;
    cpu_valid = 1'b0;
    ply_valid = 1'b0;
    idle_cycles(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
